// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the BRAM port-A arbiter.
// Requester identities, arbitration states and a saturating streak helper.
package bram_arb_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 14;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_BE_WIDTH   = 4;
   localparam int STREAK_WIDTH       = 4;

   typedef enum logic {
      REQ_IFU = 1'b0,
      REQ_LSU = 1'b1
   } req_id_e;

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } arb_state_e;

   function automatic logic [STREAK_WIDTH-1:0] sat_inc(input logic [STREAK_WIDTH-1:0] v);
      logic [STREAK_WIDTH-1:0] r;
      if (v == {STREAK_WIDTH{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(STREAK_WIDTH-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bram_arb_grant.sv
// Grant generation: m1 has fixed priority, but after MAX_STREAK m1 wins
// against a waiting m0 the FSM forces one m0 grant.
module bram_arb_grant
   import bram_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4
) (
   input  logic a_clk,
   input  logic tb_a_rst,
   input  logic m0_valid,
   input  logic m1_valid,
   output logic grant0,
   output logic grant1
);

   localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(MAX_STREAK);

   arb_state_e              state_r;
   arb_state_e              state_nxt_s;
   logic [STREAK_WIDTH-1:0] streak_r;
   logic [STREAK_WIDTH-1:0] streak_nxt_s;

   // state and streak counter registers
   always_ff @(posedge a_clk or posedge tb_a_rst) begin
      if (tb_a_rst) begin
         state_r  <= NORMAL;
         streak_r <= '0;
      end else begin
         state_r  <= state_nxt_s;
         streak_r <= streak_nxt_s;
      end
   end

   // grant vector and next-state; no grant while reset is held
   always_comb begin
      grant0       = 1'b0;
      grant1       = 1'b0;
      state_nxt_s  = state_r;
      streak_nxt_s = streak_r;
      if (tb_a_rst) begin
         state_nxt_s  = NORMAL;
         streak_nxt_s = '0;
      end else begin
         case (state_r)
            NORMAL: begin
               if (m1_valid) begin
                  grant1 = 1'b1;
                  if (m0_valid) begin
                     streak_nxt_s = sat_inc(streak_r);
                  end else begin
                     streak_nxt_s = '0;
                  end
               end else if (m0_valid) begin
                  grant0       = 1'b1;
                  streak_nxt_s = '0;
               end else begin
                  streak_nxt_s = '0;
               end
               if (streak_nxt_s >= STREAK_LIMIT) begin
                  state_nxt_s = FORCE;
               end else begin
                  state_nxt_s = NORMAL;
               end
            end
            FORCE: begin
               // a dropped m0_valid here is a protocol violation: fall back without granting
               grant0       = m0_valid;
               streak_nxt_s = '0;
               state_nxt_s  = NORMAL;
            end
            default: begin
               state_nxt_s  = NORMAL;
               streak_nxt_s = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port A between instruction fetch (m0) and load/store (m1):
// combinational issue mux plus a one-deep pending-read tracker for response routing.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BE_WIDTH   = DEFAULT_BE_WIDTH,
   parameter int MAX_STREAK = 4
) (
   input  logic                  a_clk,
   input  logic                  tb_a_rst,
   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic                  m0_req_we,
   input  logic [ADDR_WIDTH-1:0] m0_req_addr,
   input  logic [DATA_WIDTH-1:0] m0_req_wdata,
   input  logic [BE_WIDTH-1:0]   m0_req_be,
   output logic                  m0_rsp_valid,
   output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic                  m1_req_we,
   input  logic [ADDR_WIDTH-1:0] m1_req_addr,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata,
   input  logic [BE_WIDTH-1:0]   m1_req_be,
   output logic                  m1_rsp_valid,
   output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_wr_data,
   output logic                  bram_wr_en,
   output logic [BE_WIDTH-1:0]   bram_wr_byte_en,
   input  logic [DATA_WIDTH-1:0] bram_rd_data
);

   logic                  grant0_s;
   logic                  grant1_s;
   logic                  rd_issue_s;
   req_id_e               rd_owner_s;
   logic [ADDR_WIDTH-1:0] last_addr_r;
   logic [DATA_WIDTH-1:0] last_wdata_r;
   logic                  pend_valid_r;
   req_id_e               pend_owner_r;

   bram_arb_grant #(
      .MAX_STREAK (MAX_STREAK)
   ) u_grant (
      .a_clk    (a_clk),
      .tb_a_rst (tb_a_rst),
      .m0_valid (m0_req_valid),
      .m1_valid (m1_req_valid),
      .grant0   (grant0_s),
      .grant1   (grant1_s)
   );

   assign m0_req_ready = grant0_s;
   assign m1_req_ready = grant1_s;

   // issue mux: idle cycles keep the last address/data on the port
   always_comb begin
      bram_addr       = last_addr_r;
      bram_wr_data    = last_wdata_r;
      bram_wr_en      = 1'b0;
      bram_wr_byte_en = '0;
      rd_issue_s      = 1'b0;
      rd_owner_s      = REQ_IFU;
      if (grant1_s) begin
         bram_addr    = m1_req_addr;
         bram_wr_data = m1_req_wdata;
         bram_wr_en   = m1_req_we;
         if (m1_req_we) begin
            bram_wr_byte_en = m1_req_be;
         end else begin
            bram_wr_byte_en = '0;
         end
         rd_issue_s = ~m1_req_we;
         rd_owner_s = REQ_LSU;
      end else if (grant0_s) begin
         bram_addr    = m0_req_addr;
         bram_wr_data = m0_req_wdata;
         bram_wr_en   = m0_req_we;
         if (m0_req_we) begin
            bram_wr_byte_en = m0_req_be;
         end else begin
            bram_wr_byte_en = '0;
         end
         rd_issue_s = ~m0_req_we;
         rd_owner_s = REQ_IFU;
      end else begin
         rd_issue_s = 1'b0;
      end
   end

   // remembers the last issued address/data for idle cycles
   always_ff @(posedge a_clk or posedge tb_a_rst) begin
      if (tb_a_rst) begin
         last_addr_r  <= '0;
         last_wdata_r <= '0;
      end else if (grant0_s || grant1_s) begin
         last_addr_r  <= bram_addr;
         last_wdata_r <= bram_wr_data;
      end else begin
         last_addr_r  <= last_addr_r;
         last_wdata_r <= last_wdata_r;
      end
   end

   // pending read: BRAM data appears exactly one cycle after the grant
   always_ff @(posedge a_clk or posedge tb_a_rst) begin
      if (tb_a_rst) begin
         pend_valid_r <= 1'b0;
         pend_owner_r <= REQ_IFU;
      end else begin
         pend_valid_r <= rd_issue_s;
         pend_owner_r <= rd_owner_s;
      end
   end

   // response routing; the non-owner sees zero data
   always_comb begin
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
      m0_rsp_rdata = '0;
      m1_rsp_rdata = '0;
      if (pend_valid_r && (pend_owner_r == REQ_LSU)) begin
         m1_rsp_valid = 1'b1;
         m1_rsp_rdata = bram_rd_data;
      end else if (pend_valid_r) begin
         m0_rsp_valid = 1'b1;
         m0_rsp_rdata = bram_rd_data;
      end else begin
         m0_rsp_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus a
// randomized run against a priority/streak reference model and a word-array memory.
module tb_bram_port_arbiter;

   localparam int AW   = 14;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int MAXS = 4;

   logic          a_clk = 1'b0;
   logic          tb_a_rst;
   logic          init_mem;
   logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
   logic [AW-1:0] m0_req_addr;
   logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
   logic [BW-1:0] m0_req_be;
   logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
   logic [AW-1:0] m1_req_addr;
   logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
   logic [BW-1:0] m1_req_be;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wr_data;
   logic          bram_wr_en;
   logic [BW-1:0] bram_wr_byte_en;
   logic [DW-1:0] bram_rd_data;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 a_clk = ~a_clk;

   bram_port_arbiter #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BE_WIDTH (BW), .MAX_STREAK (MAXS)
   ) dut (
      .a_clk (a_clk), .tb_a_rst (tb_a_rst),
      .m0_req_valid (m0_req_valid), .m0_req_ready (m0_req_ready), .m0_req_we (m0_req_we),
      .m0_req_addr (m0_req_addr), .m0_req_wdata (m0_req_wdata), .m0_req_be (m0_req_be),
      .m0_rsp_valid (m0_rsp_valid), .m0_rsp_rdata (m0_rsp_rdata),
      .m1_req_valid (m1_req_valid), .m1_req_ready (m1_req_ready), .m1_req_we (m1_req_we),
      .m1_req_addr (m1_req_addr), .m1_req_wdata (m1_req_wdata), .m1_req_be (m1_req_be),
      .m1_rsp_valid (m1_rsp_valid), .m1_rsp_rdata (m1_rsp_rdata),
      .bram_addr (bram_addr), .bram_wr_data (bram_wr_data), .bram_wr_en (bram_wr_en),
      .bram_wr_byte_en (bram_wr_byte_en), .bram_rd_data (bram_rd_data)
   );

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      logic [DW-1:0] w;
      case (a)
         14'h0010: w = 32'hDEADBEEF;
         14'h0020: w = 32'hAAAAAAAA;
         default:  w = {8'h5A, 10'h000, a};
      endcase
      return w;
   endfunction

   // BRAM port A model: unregistered output, one-cycle read latency, byte writes
   always @(posedge a_clk) begin
      if (init_mem) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(AW'(i));
         bram_rd_data <= '0;
      end else begin
         bram_rd_data <= mem[bram_addr];
         if (bram_wr_en)
            for (int b = 0; b < BW; b++)
               if (bram_wr_byte_en[b]) mem[bram_addr][8*b +: 8] <= bram_wr_data[8*b +: 8];
      end
   end

   task automatic cyc();
      @(posedge a_clk);
      #1;
   endtask

   task automatic idle();
      m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_be = '0;
      m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_be = '0;
   endtask

   task automatic test_reset();
      logic [4:0] flags;
      tb_a_rst = 1'b1;
      m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_addr = 14'h0123; m0_req_wdata = 32'h11111111; m0_req_be = 4'hF;
      m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 14'h0456;
      cyc(); #3;
      flags = {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, bram_wr_en};
      tests_run++;
      if (flags !== 5'b00000) begin
         tests_failed++; $display("FAIL reset_flags: got %b expected 00000", flags);
      end
      tests_run++;
      if ({bram_addr, bram_wr_data, bram_wr_byte_en, m0_rsp_rdata, m1_rsp_rdata} !== {AW'(0), DW'(0), BW'(0), DW'(0), DW'(0)}) begin
         tests_failed++; $display("FAIL reset_buses: addr %h wdata %h be %h", bram_addr, bram_wr_data, bram_wr_byte_en);
      end
      idle();
      cyc();
      tb_a_rst = 1'b0;
      cyc(); #3;
      tests_run++;
      if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, bram_wr_en} !== 5'b00000) begin
         tests_failed++; $display("FAIL post_reset_idle: got %b expected 00000",
                                  {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, bram_wr_en});
      end
   endtask

   task automatic test_single_read();
      cyc();
      m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 14'h0010;
      #3;
      tests_run++;
      if ({m0_req_ready, m1_req_ready, bram_wr_en, bram_addr} !== {3'b100, 14'h0010}) begin
         tests_failed++; $display("FAIL m0_read_issue: rdy0 %b rdy1 %b we %b addr %h expected 1 0 0 0010",
                                  m0_req_ready, m1_req_ready, bram_wr_en, bram_addr);
      end
      cyc(); idle(); #3;
      tests_run++;
      if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
         tests_failed++; $display("FAIL m0_read_rsp: v0 %b v1 %b d0 %h d1 %h expected 1 0 deadbeef 0",
                                  m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata);
      end
   endtask

   task automatic test_write_then_read();
      cyc();
      m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 14'h0020; m1_req_wdata = 32'h12345678; m1_req_be = 4'b0011;
      #3;
      tests_run++;
      if ({m1_req_ready, m0_req_ready, bram_wr_en, bram_wr_byte_en, bram_addr, bram_wr_data} !==
          {3'b101, 4'b0011, 14'h0020, 32'h12345678}) begin
         tests_failed++; $display("FAIL m1_write_issue: rdy1 %b we %b be %b addr %h data %h",
                                  m1_req_ready, bram_wr_en, bram_wr_byte_en, bram_addr, bram_wr_data);
      end
      cyc();
      m1_req_we = 1'b0;
      #3;
      tests_run++;
      if ({m1_req_ready, bram_wr_en, bram_wr_byte_en, m1_rsp_valid} !== {2'b10, 4'b0000, 1'b0}) begin
         tests_failed++; $display("FAIL m1_read_issue: rdy1 %b we %b be %b rsp1 %b expected 1 0 0000 0",
                                  m1_req_ready, bram_wr_en, bram_wr_byte_en, m1_rsp_valid);
      end
      cyc(); idle(); #3;
      tests_run++;
      if ({m1_rsp_valid, m0_rsp_valid, bram_wr_en, m1_rsp_rdata} !== {3'b100, 32'hAAAA5678}) begin
         tests_failed++; $display("FAIL m1_partial_write_rsp: v1 %b v0 %b we %b d1 %h expected 1 0 0 aaaa5678",
                                  m1_rsp_valid, m0_rsp_valid, bram_wr_en, m1_rsp_rdata);
      end
   endtask

   task automatic test_streak();
      int   m0_grants = 0;
      logic exp0;
      cyc();
      m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 14'h0001;
      m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 14'h0002;
      for (int i = 0; i < 3 * (MAXS + 1); i++) begin
         #3;
         exp0 = ((i % (MAXS + 1)) == MAXS);
         tests_run++;
         if ({m0_req_ready, m1_req_ready} !== {exp0, ~exp0}) begin
            tests_failed++; $display("FAIL streak_cycle%0d: got %b%b expected %b%b",
                                     i, m0_req_ready, m1_req_ready, exp0, ~exp0);
         end
         if (m0_req_ready) m0_grants++;
         cyc();
      end
      idle();
      tests_run++;
      if (m0_grants !== 3) begin
         tests_failed++; $display("FAIL streak_m0_count: got %0d expected 3", m0_grants);
      end
   endtask

   task automatic test_same_addr();
      cyc();
      m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 14'h0100;
      m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 14'h0100; m1_req_wdata = 32'hCAFEF00D; m1_req_be = 4'hF;
      #3;
      tests_run++;
      if ({m0_req_ready, m1_req_ready, bram_wr_en} !== 3'b011) begin
         tests_failed++; $display("FAIL same_addr_first: got %b expected 011", {m0_req_ready, m1_req_ready, bram_wr_en});
      end
      cyc();
      m1_req_valid = 1'b0;
      #3;
      tests_run++;
      if ({m0_req_ready, m1_req_ready, bram_wr_en, bram_addr} !== {3'b100, 14'h0100}) begin
         tests_failed++; $display("FAIL same_addr_second: got %b addr %h expected 100 0100",
                                  {m0_req_ready, m1_req_ready, bram_wr_en}, bram_addr);
      end
      cyc(); idle(); #3;
      tests_run++;
      if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
         tests_failed++; $display("FAIL same_addr_rsp: v0 %b d0 %h expected 1 cafef00d", m0_rsp_valid, m0_rsp_rdata);
      end
   endtask

   task automatic test_reset_mid();
      cyc();
      m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 14'h0020;
      #3;
      tests_run++;
      if (m1_req_ready !== 1'b1) begin
         tests_failed++; $display("FAIL rst_mid_grant: got %b expected 1", m1_req_ready);
      end
      cyc(); idle(); tb_a_rst = 1'b1; #3;
      tests_run++;
      if ({m1_rsp_valid, m0_rsp_valid, m1_rsp_rdata, bram_wr_en, bram_addr} !== {2'b00, 32'h0, 1'b0, 14'h0}) begin
         tests_failed++; $display("FAIL rst_mid_discard: v1 %b v0 %b d1 %h addr %h expected 0 0 0 0",
                                  m1_rsp_valid, m0_rsp_valid, m1_rsp_rdata, bram_addr);
      end
      cyc(); tb_a_rst = 1'b0; #3;
      tests_run++;
      if ({m1_rsp_valid, m0_rsp_valid} !== 2'b00) begin
         tests_failed++; $display("FAIL rst_mid_release: got %b expected 00", {m1_rsp_valid, m0_rsp_valid});
      end
      cyc();
      m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 14'h0010;
      #3;
      tests_run++;
      if (m0_req_ready !== 1'b1) begin
         tests_failed++; $display("FAIL rst_mid_next_grant: got %b expected 1", m0_req_ready);
      end
      cyc(); idle(); #3;
      tests_run++;
      if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         tests_failed++; $display("FAIL rst_mid_next_rsp: v0 %b d0 %h expected 1 deadbeef", m0_rsp_valid, m0_rsp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int rsp_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         cyc();
         if (i < 8) begin
            m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = AW'(i);
         end else begin
            idle();
         end
         #3;
         if (i < 8) begin
            tests_run++;
            if (m0_req_ready !== 1'b1) begin
               tests_failed++; $display("FAIL b2b_grant%0d: got %b expected 1", i, m0_req_ready);
            end
         end
         if (i > 0) begin
            tests_run++;
            if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, init_word(AW'(i - 1))}) begin
               tests_failed++; $display("FAIL b2b_rsp%0d: v0 %b d0 %h expected 1 %h",
                                        i - 1, m0_rsp_valid, m0_rsp_rdata, init_word(AW'(i - 1)));
            end
            if (m0_rsp_valid) rsp_cnt++;
         end
      end
      tests_run++;
      if (rsp_cnt !== 8) begin
         tests_failed++; $display("FAIL b2b_rsp_count: got %0d expected 8", rsp_cnt);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] ref_mem [0:31];
      int            streak = 0;
      logic          pend_v = 1'b0;
      logic          pend_own = 1'b0;
      logic [DW-1:0] pend_data = '0;
      logic          g0, g1, w_we;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_data;
      logic [BW-1:0] w_be;
      logic [4:0]    idx;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_word(14'h0200 + AW'(i));
      idle();
      cyc();
      for (int c = 0; c < 400; c++) begin
         if (!m0_req_valid && ($urandom_range(0, 9) < 7)) begin
            m0_req_valid = 1'b1; m0_req_we = 1'($urandom_range(0, 1));
            m0_req_addr = 14'h0200 + AW'($urandom_range(0, 31));
            m0_req_wdata = $urandom; m0_req_be = BW'($urandom_range(0, 15));
         end
         if (!m1_req_valid && ($urandom_range(0, 9) < 7)) begin
            m1_req_valid = 1'b1; m1_req_we = 1'($urandom_range(0, 1));
            m1_req_addr = 14'h0200 + AW'($urandom_range(0, 31));
            m1_req_wdata = $urandom; m1_req_be = BW'($urandom_range(0, 15));
         end
         #3;
         // m1 wins unless m0 has already watched MAXS m1 grants go by
         g0 = m0_req_valid && ((streak >= MAXS) || !m1_req_valid);
         g1 = m1_req_valid && !g0;
         w_we = g1 ? m1_req_we : m0_req_we;
         w_addr = g1 ? m1_req_addr : m0_req_addr;
         w_data = g1 ? m1_req_wdata : m0_req_wdata;
         w_be = g1 ? m1_req_be : m0_req_be;
         tests_run++;
         if ({m0_req_ready, m1_req_ready} !== {g0, g1}) begin
            tests_failed++; $display("FAIL rnd_grant c%0d: got %b%b expected %b%b", c, m0_req_ready, m1_req_ready, g0, g1);
         end
         tests_run++;
         if (g0 || g1) begin
            if ({bram_addr, bram_wr_en, bram_wr_byte_en} !== {w_addr, w_we, (w_we ? w_be : 4'b0000)} ||
                (w_we && (bram_wr_data !== w_data))) begin
               tests_failed++; $display("FAIL rnd_issue c%0d: addr %h we %b be %b data %h expected %h %b %b %h",
                                        c, bram_addr, bram_wr_en, bram_wr_byte_en, bram_wr_data, w_addr, w_we, w_be, w_data);
            end
         end else if ({bram_wr_en, bram_wr_byte_en} !== 5'b00000) begin
            tests_failed++; $display("FAIL rnd_idle c%0d: we %b be %b expected 0 0000", c, bram_wr_en, bram_wr_byte_en);
         end
         tests_run++;
         if ({m0_rsp_valid, m1_rsp_valid} !== {pend_v && !pend_own, pend_v && pend_own} ||
             (pend_v && ((pend_own ? m1_rsp_rdata : m0_rsp_rdata) !== pend_data))) begin
            tests_failed++; $display("FAIL rnd_rsp c%0d: v0 %b v1 %b d0 %h d1 %h expected v %b own %b data %h",
                                     c, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata, pend_v, pend_own, pend_data);
         end
         pend_v = 1'b0;
         if (g0 || g1) begin
            idx = w_addr[4:0];
            if (w_we) begin
               for (int b = 0; b < BW; b++)
                  if (w_be[b]) ref_mem[idx][8*b +: 8] = w_data[8*b +: 8];
            end else begin
               pend_v = 1'b1; pend_own = g1; pend_data = ref_mem[idx];
            end
         end
         if (g0 || !m0_req_valid) streak = 0;
         else if (g1) streak++;
         cyc();
         if (g0) m0_req_valid = 1'b0;
         if (g1) m1_req_valid = 1'b0;
      end
      idle();
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tb_a_rst = 1'b1;
      init_mem = 1'b1;
      idle();
      cyc();
      init_mem = 1'b0;
      test_reset();
      test_single_read();
      test_write_then_read();
      test_streak();
      test_same_addr();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
